// File: rtl/sifive_scope_pkg.sv
// Shared types for the TileLink D-channel trace scope.
// State encoding, entry layout and D opcodes.
package sifive_scope_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_USER_W   = 4;
  localparam int unsigned DEF_SOURCE_W = 4;
  localparam int unsigned DEF_SIZE_W   = 3;
  localparam int unsigned DEF_TS_W     = 16;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  // Default-width entry; opcode sits in the LSBs.
  typedef struct packed {
    logic [DEF_TS_W-1:0]     ts;
    logic [DEF_USER_W-1:0]   user;
    logic                    corrupt;
    logic                    denied;
    logic [DEF_SIZE_W-1:0]   size;
    logic [DEF_SOURCE_W-1:0] source;
    logic [2:0]              opcode;
  } entry_t;

endpackage

// File: rtl/sifive_scope_trace_ram.sv
// Trace storage: one write port, registered read port.
// A same-cycle write to the read address returns old data.
module sifive_scope_trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Write and read share the edge; NBA gives read-old.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sifive_scope_tl_d_trace.sv
// TileLink D-channel trace scope: snoops fired beats into a
// circular buffer, freezes on trigger plus post-count.
module sifive_scope_tl_d_trace
  import sifive_scope_pkg::*;
#(
  parameter  int USER_W   = 4,
  parameter  int SOURCE_W = 4,
  parameter  int SIZE_W   = 3,
  parameter  int DEPTH    = 16,
  parameter  int TS_W     = 16,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH) + 1,
  localparam int ENTRY_W  = TS_W + USER_W + 2 + SIZE_W
                          + SOURCE_W + 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic [SIZE_W-1:0]   d_size,
  input  logic                d_denied,
  input  logic                d_corrupt,
  input  logic [USER_W-1:0]   d_user,
  input  logic                arm,
  input  logic                stop,
  input  logic                trig_opcode_en,
  input  logic [2:0]          trig_opcode,
  input  logic [USER_W-1:0]   trig_user_val,
  input  logic [USER_W-1:0]   trig_user_mask,
  input  logic [CNT_W-1:0]    post_count,
  output logic [1:0]          state,
  output logic                triggered,
  output logic [CNT_W-1:0]    captured,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic [ENTRY_W-1:0]  rd_data
);

  typedef struct packed {
    logic [TS_W-1:0]     ts;
    logic [USER_W-1:0]   user;
    logic                corrupt;
    logic                denied;
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic [2:0]          opcode;
  } ent_t;

  localparam logic [CNT_W-1:0] MAXPOST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

  state_e             state_q;
  logic               trig_q;
  logic [CNT_W-1:0]   cap_q;
  logic [CNT_W-1:0]   post_q;
  logic [IDX_W-1:0]   wptr_q;
  logic [TS_W-1:0]    ts_q;
  logic               rd_valid_q;
  logic               rd_hit_q;

  logic               fire;
  logic               op_hit;
  logic               user_hit;
  logic               match;
  logic               capturing;
  logic               wr_en;
  logic [CNT_W-1:0]   post_clamp;
  logic [TS_W-1:0]    ts_now;
  logic [IDX_W-1:0]   raddr;
  logic               rd_hit;
  ent_t               wentry;
  logic [ENTRY_W-1:0] ram_rdata;

  assign fire     = d_valid & d_ready;
  assign op_hit   = !trig_opcode_en
                 || (d_opcode == trig_opcode);
  assign user_hit = ((d_user ^ trig_user_val)
                  & trig_user_mask) == '0;
  assign match    = fire & op_hit & user_hit;

  assign capturing = (state_q == ST_ARMED)
                  || (state_q == ST_POST);
  assign wr_en     = capturing & fire & ~arm;

  assign post_clamp = (post_count > MAXPOST)
                    ? MAXPOST : post_count;

  // Arm zeroes the stamp in its own cycle.
  assign ts_now = arm ? '0 : ts_q;

  assign wentry.ts      = ts_now;
  assign wentry.user    = d_user;
  assign wentry.corrupt = d_corrupt;
  assign wentry.denied  = d_denied;
  assign wentry.size    = d_size;
  assign wentry.source  = d_source;
  assign wentry.opcode  = d_opcode;

  assign raddr  = wptr_q - cap_q[IDX_W-1:0] + rd_idx;
  assign rd_hit = CNT_W'(rd_idx) < cap_q;

  // Capture FSM, pointers, counters and timestamp.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      cap_q   <= '0;
      post_q  <= '0;
      wptr_q  <= '0;
      ts_q    <= '0;
    end else begin
      ts_q <= ts_now + 1'b1;
      if (arm) begin
        state_q <= ST_ARMED;
        trig_q  <= 1'b0;
        cap_q   <= '0;
        wptr_q  <= '0;
        post_q  <= post_clamp;
      end else begin
        if (wr_en) begin
          wptr_q <= wptr_q + 1'b1;
          if (cap_q != FULL) cap_q <= cap_q + 1'b1;
        end
        unique case (state_q)
          ST_ARMED: begin
            if (match) begin
              trig_q  <= 1'b1;
              state_q <= (post_q == '0 || stop)
                       ? ST_DONE : ST_POST;
            end else if (stop) begin
              state_q <= ST_DONE;
            end
          end
          ST_POST: begin
            if (fire) post_q <= post_q - 1'b1;
            if (stop || (fire && post_q == CNT_W'(1)))
              state_q <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // Read-side qualifiers aligned with the RAM output.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_hit_q <= rd_hit;
    end
  end

  sifive_scope_trace_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wentry),
    .re_i    (rd_en),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  assign state     = state_q;
  assign triggered = trig_q;
  assign captured  = cap_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_hit_q ? ram_rdata : '0;

endmodule

// File: tb/tb_sifive_scope_tl_d_trace.sv
// Bench for the D-channel trace scope: directed beats,
// read results checked through a scoreboard queue.
module tb_sifive_scope_tl_d_trace;

  localparam int DEPTH   = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;
  localparam int ENTRY_W = 32;

  logic               clock = 1'b0;
  logic               reset;
  logic               d_valid, d_ready;
  logic [2:0]         d_opcode;
  logic [3:0]         d_source;
  logic [2:0]         d_size;
  logic               d_denied, d_corrupt;
  logic [3:0]         d_user;
  logic               arm, stop;
  logic               trig_opcode_en;
  logic [2:0]         trig_opcode;
  logic [3:0]         trig_user_val, trig_user_mask;
  logic [CNT_W-1:0]   post_count;
  logic [1:0]         state;
  logic               triggered;
  logic [CNT_W-1:0]   captured;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [ENTRY_W-1:0] exp_q [$];
  string              name_q [$];

  sifive_scope_tl_d_trace #(
    .USER_W (4), .SOURCE_W (4), .SIZE_W (3),
    .DEPTH (DEPTH), .TS_W (16)
  ) dut (
    .clock (clock), .reset (reset),
    .d_valid (d_valid), .d_ready (d_ready),
    .d_opcode (d_opcode), .d_source (d_source),
    .d_size (d_size), .d_denied (d_denied),
    .d_corrupt (d_corrupt), .d_user (d_user),
    .arm (arm), .stop (stop),
    .trig_opcode_en (trig_opcode_en),
    .trig_opcode (trig_opcode),
    .trig_user_val (trig_user_val),
    .trig_user_mask (trig_user_mask),
    .post_count (post_count),
    .state (state), .triggered (triggered),
    .captured (captured),
    .rd_en (rd_en), .rd_idx (rd_idx),
    .rd_valid (rd_valid), .rd_data (rd_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(
    input logic [15:0] ts, input logic [3:0] usr,
    input logic cor, input logic den,
    input logic [2:0] sz, input logic [3:0] src,
    input logic [2:0] op);
    return {ts, usr, cor, den, sz, src, op};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [2:0] op,
                      input logic [3:0] src,
                      input logic [3:0] usr = 4'h0,
                      input logic cor = 1'b0,
                      input logic den = 1'b0);
    d_valid   = 1'b1;
    d_ready   = 1'b1;
    d_opcode  = op;
    d_source  = src;
    d_user    = usr;
    d_corrupt = cor;
    d_denied  = den;
    tick();
    d_valid   = 1'b0;
    d_corrupt = 1'b0;
    d_denied  = 1'b0;
  endtask

  task automatic do_arm(input logic [CNT_W-1:0] pc);
    arm        = 1'b1;
    post_count = pc;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(input logic [IDX_W-1:0] idx,
                    input logic [31:0] exp,
                    input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic trig_cfg(input logic en,
                          input logic [2:0] op,
                          input logic [3:0] val,
                          input logic [3:0] msk);
    trig_opcode_en = en;
    trig_opcode    = op;
    trig_user_val  = val;
    trig_user_mask = msk;
  endtask

  // Scoreboard monitor: every returned read is matched.
  always @(negedge clock) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got %h", rd_data);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL %s got %h want %h",
                   n, rd_data, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    d_valid = 1'b0; d_ready = 1'b0;
    d_opcode = '0; d_source = '0; d_size = 3'd2;
    d_denied = 1'b0; d_corrupt = 1'b0; d_user = '0;
    arm = 1'b0; stop = 1'b0; post_count = '0;
    rd_en = 1'b0; rd_idx = '0;
    trig_cfg(1'b0, 3'd0, 4'h0, 4'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_state", state, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_cap", captured, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdd", rd_data, 0);

    // 1: opcode trigger on GrantData, post 2
    trig_cfg(1'b1, 3'd5, 4'h0, 4'h0);
    do_arm(4'd2);
    chk("t1_armed", state, 1);
    for (int i = 0; i < 12; i++)
      beat(3'd1, 4'(i));
    chk("t1_pre_trig", triggered, 0);
    beat(3'd5, 4'd12);
    chk("t1_post", state, 2);
    chk("t1_trig", triggered, 1);
    beat(3'd1, 4'd13);
    beat(3'd1, 4'd14);
    chk("t1_done", state, 3);
    beat(3'd1, 4'd15);
    chk("t1_cap", captured, 8);
    chk("t1_still_done", state, 3);
    rd(3'd0, mk(16'd8, 4'h0, 0, 0, 3'd2, 4'd7, 3'd1),
       "t1_rd0");
    rd(3'd5, mk(16'd13, 4'h0, 0, 0, 3'd2, 4'd12, 3'd5),
       "t1_rd5");
    rd(3'd7, mk(16'd15, 4'h0, 0, 0, 3'd2, 4'd14, 3'd1),
       "t1_rd7");

    // 2: user-mask trigger, post 0
    trig_cfg(1'b0, 3'd0, 4'b1000, 4'b1100);
    do_arm(4'd0);
    chk("t2_cap_clr", captured, 0);
    beat(3'd0, 4'd1, 4'h4);
    chk("t2_no_trig4", state, 1);
    beat(3'd0, 4'd2, 4'h3);
    chk("t2_no_trig3", triggered, 0);
    beat(3'd0, 4'd3, 4'hB);
    chk("t2_done", state, 3);
    chk("t2_trig", triggered, 1);
    chk("t2_cap", captured, 3);
    rd(3'd2, mk(16'd3, 4'hB, 0, 0, 3'd2, 4'd3, 3'd0),
       "t2_rd2");

    // 3: clamped post count, trigger on first beat
    trig_cfg(1'b1, 3'd4, 4'h0, 4'h0);
    do_arm(4'd15);
    beat(3'd4, 4'd0);
    for (int i = 1; i < 7; i++)
      beat(3'd0, 4'(i));
    chk("t3_still_post", state, 2);
    beat(3'd0, 4'd7);
    chk("t3_done", state, 3);
    chk("t3_cap", captured, 8);
    beat(3'd0, 4'd8);
    chk("t3_cap_frozen", captured, 8);
    rd(3'd0, mk(16'd1, 4'h0, 0, 0, 3'd2, 4'd0, 3'd4),
       "t3_rd0");
    rd(3'd7, mk(16'd8, 4'h0, 0, 0, 3'd2, 4'd7, 3'd0),
       "t3_rd7");

    // 4: arm with fire, then stop with fire
    trig_cfg(1'b1, 3'd6, 4'h0, 4'h0);
    arm = 1'b1;
    post_count = 4'd3;
    beat(3'd0, 4'd3);
    arm = 1'b0;
    chk("t4_arm_fire_cap", captured, 0);
    chk("t4_arm_state", state, 1);
    stop = 1'b1;
    beat(3'd0, 4'd9);
    stop = 1'b0;
    chk("t4_stop_state", state, 3);
    chk("t4_stop_trig", triggered, 0);
    chk("t4_stop_cap", captured, 1);
    rd(3'd0, mk(16'd1, 4'h0, 0, 0, 3'd2, 4'd9, 3'd0),
       "t4_rd0");

    // 5: reset in the middle of POST
    trig_cfg(1'b1, 3'd4, 4'h0, 4'h0);
    do_arm(4'd5);
    beat(3'd0, 4'd1);
    beat(3'd4, 4'd2);
    beat(3'd0, 4'd3);
    chk("t5_post", state, 2);
    chk("t5_cap3", captured, 3);
    reset  = 1'b1;
    rd_en  = 1'b1;
    rd_idx = 3'd0;
    tick();
    reset = 1'b0;
    rd_en = 1'b0;
    chk("t5_rst_state", state, 0);
    chk("t5_rst_cap", captured, 0);
    chk("t5_rst_rdv", rd_valid, 0);
    beat(3'd0, 4'd4);
    beat(3'd4, 4'd5);
    chk("t5_idle_cap", captured, 0);
    chk("t5_idle_state", state, 0);
    chk("t5_idle_trig", triggered, 0);

    // 6: timestamp and out-of-range read
    do_arm(4'd0);
    for (int i = 0; i < 4; i++) tick();
    beat(3'd0, 4'd1, 4'h0, 1'b1, 1'b1);
    beat(3'd0, 4'd2);
    beat(3'd0, 4'd3);
    beat(3'd0, 4'd4);
    chk("t6_cap4", captured, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_done", state, 3);
    rd(3'd6, 32'h0, "t6_rd_oob");
    rd(3'd0, mk(16'd5, 4'h0, 1, 1, 3'd2, 4'd1, 3'd0),
       "t6_rd_ts");

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_reads got %0d want 0",
               exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
